// File: rtl/ps2_pkg.sv
// ps2_pkg
//   Shared definitions for the PS/2 host-side blocks: the transmitter state
//   enum, the keyboard command/response byte constants, and small helpers
//   used to size timers and compute the frame parity bit.
//   No ports; import with "import ps2_pkg::*;".
package ps2_pkg;

    // Transmitter sequencing states, in the order a normal transfer visits them.
    typedef enum logic [2:0] {
        IDLE,
        INHIBIT,
        REQ,
        WAIT_FIRST,
        SHIFT,
        ACK,
        WAIT_IDLE,
        ABORT
    } ps2State_e;

    // Host-to-keyboard commands and the keyboard's acknowledge byte.
    localparam logic [7:0] PS2_CMD_SETLED = 8'hED;
    localparam logic [7:0] PS2_CMD_RESET  = 8'hFF;
    localparam logic [7:0] PS2_CMD_ENABLE = 8'hF4;
    localparam logic [7:0] PS2_CMD_RESEND = 8'hFE;
    localparam logic [7:0] PS2_RSP_ACK    = 8'hFA;

    // Whole clock cycles in a microsecond interval; all protocol timers use this.
    function automatic int unsigned ps2UsToCycles(input int unsigned clkHz,
                                                  input int unsigned us);
        return (clkHz / 32'd1_000_000) * us;
    endfunction

    // PS/2 frames carry odd parity: data plus parity has an odd number of ones.
    function automatic logic ps2OddParity(input logic [7:0] data);
        return ~^data;
    endfunction

endpackage

// File: rtl/ps2_line_filter.sv
// ps2_line_filter
//   Brings one asynchronous PS/2 line into the system clock domain and
//   removes short glitches. The synchronised level must differ from the
//   accepted level for FILTER_LEN consecutive cycles before the accepted
//   level changes. A one-cycle pulse marks each accepted 1->0 transition.
//   Usable for either line of the host transmitter or the receiver.
// Ports
//   clk_i    in   system clock
//   rst_i    in   asynchronous active-high reset (line assumed idle high)
//   line_i   in   raw pin level, asynchronous
//   level_o  out  filtered line level
//   fall_o   out  one-cycle pulse when the filtered level goes 1->0
module ps2_line_filter #(
    parameter int unsigned FILTER_LEN = 8
) (
    input  logic clk_i,
    input  logic rst_i,
    input  logic line_i,
    output logic level_o,
    output logic fall_o
);

    localparam int unsigned CNT_W = (FILTER_LEN > 1) ? $clog2(FILTER_LEN) : 1;

    logic [1:0]       sync_q;
    logic             level_q, level_d;
    logic             fall_q, fall_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;

    // Any agreement with the accepted level restarts the stability count,
    // so a disturbance shorter than FILTER_LEN cycles never gets through.
    always_comb begin
        level_d = level_q;
        fall_d  = 1'b0;
        cnt_d   = '0;
        if (sync_q[1] != level_q) begin
            if (cnt_q == CNT_W'(FILTER_LEN - 1)) begin
                level_d = sync_q[1];
                fall_d  = ~sync_q[1];
            end else begin
                cnt_d = cnt_q + CNT_W'(1);
            end
        end
    end

    // Lines idle high, so reset the chain and the filter to 1.
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            sync_q  <= 2'b11;
            level_q <= 1'b1;
            fall_q  <= 1'b0;
            cnt_q   <= '0;
        end else begin
            sync_q  <= {sync_q[0], line_i};
            level_q <= level_d;
            fall_q  <= fall_d;
            cnt_q   <= cnt_d;
        end
    end

    assign level_o = level_q;
    assign fall_o  = fall_q;

endmodule

// File: rtl/ps2_host_tx.sv
// ps2_host_tx
//   Host-to-device PS/2 transmitter. Requests to send by holding the clock
//   low, presents the start bit, then lets the keyboard clock out eight data
//   bits (LSB first), odd parity and the stop bit, and finally checks the
//   keyboard's ACK bit. Exactly one of tx_done / tx_error pulses for every
//   accepted byte. Both pins are open-collector: an *_oe of 1 pulls low.
// Ports
//   CLOCK_50    in   system clock
//   RESET       in   asynchronous active-high reset
//   tx_data     in   byte to send
//   tx_valid    in   send request, taken when tx_valid && tx_ready
//   tx_ready    out  high only while idle
//   tx_done     out  one-cycle pulse: byte sent and acknowledged
//   tx_error    out  one-cycle pulse: timeout or missing ACK
//   busy        out  high whenever not idle
//   ps2_clk_in  in   raw PS2_CLK pin level
//   ps2_dat_in  in   raw PS2_DAT pin level
//   ps2_clk_oe  out  1 = pull PS2_CLK low
//   ps2_dat_oe  out  1 = pull PS2_DAT low
module ps2_host_tx
    import ps2_pkg::*;
#(
    parameter int unsigned CLK_FREQ_HZ      = 50_000_000,
    parameter int unsigned INHIBIT_US       = 120,
    parameter int unsigned START_TIMEOUT_US = 15000,
    parameter int unsigned XFER_TIMEOUT_US  = 2000,
    parameter int unsigned FILTER_LEN       = 8
) (
    input  logic       CLOCK_50,
    input  logic       RESET,
    input  logic [7:0] tx_data,
    input  logic       tx_valid,
    output logic       tx_ready,
    output logic       tx_done,
    output logic       tx_error,
    output logic       busy,
    input  logic       ps2_clk_in,
    input  logic       ps2_dat_in,
    output logic       ps2_clk_oe,
    output logic       ps2_dat_oe
);

    localparam int unsigned INHIBIT_CYC = ps2UsToCycles(CLK_FREQ_HZ, INHIBIT_US);
    localparam int unsigned START_CYC   = ps2UsToCycles(CLK_FREQ_HZ, START_TIMEOUT_US);
    localparam int unsigned XFER_CYC    = ps2UsToCycles(CLK_FREQ_HZ, XFER_TIMEOUT_US);
    localparam int unsigned MAX_A       = (INHIBIT_CYC > START_CYC) ? INHIBIT_CYC : START_CYC;
    localparam int unsigned MAX_CYC     = (MAX_A > XFER_CYC) ? MAX_A : XFER_CYC;
    localparam int unsigned TIMER_W     = (MAX_CYC > 1) ? $clog2(MAX_CYC) : 1;

    ps2State_e          state_q, state_d;
    logic [TIMER_W-1:0] timer_q, timer_d;
    logic [8:0]         shift_q, shift_d;
    logic [3:0]         bitIdx_q, bitIdx_d;
    logic               ackOk_q, ackOk_d;
    logic               datOe_q, datOe_d;

    logic clkLevel, clkFall;
    logic datLevel, unusedDatFall;
    logic timerZero;

    ps2_line_filter #(.FILTER_LEN(FILTER_LEN)) uClkFilter (
        .clk_i   (CLOCK_50),
        .rst_i   (RESET),
        .line_i  (ps2_clk_in),
        .level_o (clkLevel),
        .fall_o  (clkFall)
    );

    ps2_line_filter #(.FILTER_LEN(FILTER_LEN)) uDatFilter (
        .clk_i   (CLOCK_50),
        .rst_i   (RESET),
        .line_i  (ps2_dat_in),
        .level_o (datLevel),
        .fall_o  (unusedDatFall)
    );

    assign timerZero = (timer_q == '0);

    // Next-state logic. The shared timer free-runs down to zero and is
    // reloaded on entry to INHIBIT, WAIT_FIRST and SHIFT; the transfer
    // timeout loaded at the first fall keeps running through ACK and WAIT_IDLE.
    // shift_q holds {parity, data} and is consumed LSB first, one bit per fall.
    always_comb begin
        state_d  = state_q;
        timer_d  = timerZero ? timer_q : timer_q - TIMER_W'(1);
        shift_d  = shift_q;
        bitIdx_d = bitIdx_q;
        ackOk_d  = ackOk_q;
        datOe_d  = datOe_q;
        tx_done  = 1'b0;
        tx_error = 1'b0;

        case (state_q)
            IDLE: begin
                datOe_d = 1'b0;
                if (tx_valid) begin
                    shift_d = {ps2OddParity(tx_data), tx_data};
                    timer_d = TIMER_W'(INHIBIT_CYC - 1);
                    state_d = INHIBIT;
                end
            end

            INHIBIT: begin
                // Start bit goes out on the last inhibit cycle so data is
                // already low when the clock is released.
                if (timer_q == TIMER_W'(1) || timerZero) begin
                    datOe_d = 1'b1;
                end
                if (timerZero) begin
                    state_d = REQ;
                end
            end

            REQ: begin
                timer_d = TIMER_W'(START_CYC - 1);
                state_d = WAIT_FIRST;
            end

            WAIT_FIRST: begin
                if (clkFall) begin
                    datOe_d  = ~shift_q[0];
                    shift_d  = shift_q >> 1;
                    bitIdx_d = 4'd1;
                    timer_d  = TIMER_W'(XFER_CYC - 1);
                    state_d  = SHIFT;
                end else if (timerZero) begin
                    state_d = ABORT;
                end
            end

            SHIFT: begin
                if (timerZero) begin
                    state_d = ABORT;
                end else if (clkFall) begin
                    // Indices 1..8 carry data bits 1..7 and parity; the
                    // ninth fall releases data for the stop bit.
                    if (bitIdx_q == 4'd9) begin
                        datOe_d = 1'b0;
                        state_d = ACK;
                    end else begin
                        datOe_d  = ~shift_q[0];
                        shift_d  = shift_q >> 1;
                        bitIdx_d = bitIdx_q + 4'd1;
                    end
                end
            end

            ACK: begin
                if (timerZero) begin
                    state_d = ABORT;
                end else if (clkFall) begin
                    ackOk_d = ~datLevel;
                    state_d = WAIT_IDLE;
                end
            end

            WAIT_IDLE: begin
                if (clkLevel && datLevel) begin
                    tx_done  = ackOk_q;
                    tx_error = ~ackOk_q;
                    state_d  = IDLE;
                end else if (timerZero) begin
                    state_d = ABORT;
                end
            end

            ABORT: begin
                tx_error = 1'b1;
                state_d  = IDLE;
            end

            default: begin
                state_d = IDLE;
            end
        endcase

        if (state_d == ABORT || state_d == IDLE) begin
            datOe_d = 1'b0;
        end
    end

    // Async reset releases both lines at once and drops any transfer silently.
    always_ff @(posedge CLOCK_50 or posedge RESET) begin
        if (RESET) begin
            state_q  <= IDLE;
            timer_q  <= '0;
            shift_q  <= '0;
            bitIdx_q <= '0;
            ackOk_q  <= 1'b0;
            datOe_q  <= 1'b0;
        end else begin
            state_q  <= state_d;
            timer_q  <= timer_d;
            shift_q  <= shift_d;
            bitIdx_q <= bitIdx_d;
            ackOk_q  <= ackOk_d;
            datOe_q  <= datOe_d;
        end
    end

    assign ps2_clk_oe = (state_q == INHIBIT) || (state_q == REQ);
    assign ps2_dat_oe = datOe_q;
    assign tx_ready   = (state_q == IDLE);
    assign busy       = (state_q != IDLE);

endmodule

// File: tb/tb_ps2_host_tx.sv
// tb_ps2_host_tx
//   Bench for ps2_host_tx. A keyboard model shares both lines with the DUT
//   as a wired-AND, clocks at 12.5 kHz, records each frame bit just before
//   the falling edge that follows it and answers with an ACK. Expected
//   frames come from plain arithmetic on the byte sent.
module tb_ps2_host_tx;
    import ps2_pkg::*;

    // A 2 MHz system clock keeps every protocol timer short enough to run.
    localparam int CLK_HZ     = 2_000_000;
    localparam int INH_US     = 120;
    localparam int START_US   = 5000;
    localparam int XFER_US    = 2000;
    localparam int CYC_PER_US = CLK_HZ / 1_000_000;
    localparam int INH_CYC    = CYC_PER_US * INH_US;
    localparam int START_CYC  = CYC_PER_US * START_US;
    localparam int XFER_CYC   = CYC_PER_US * XFER_US;
    localparam int HALF       = 40 * CYC_PER_US;

    logic       CLOCK_50 = 1'b0;
    logic       RESET    = 1'b1;
    logic [7:0] tx_data  = 8'h00;
    logic       tx_valid = 1'b0;
    logic       tx_ready, tx_done, tx_error, busy;
    logic       ps2_clk_oe, ps2_dat_oe;
    logic       bfmClk = 1'b1;
    logic       bfmDat = 1'b1;
    logic       clkLine, datLine;

    int assertCount = 0;
    int failCount   = 0;
    int cycle       = 0;
    int doneCount   = 0;
    int errCount    = 0;
    int errCycle    = 0;
    int lowRun      = 0;
    int lastLowRun  = 0;
    logic [7:0] curData = 8'h00;

    assign clkLine = bfmClk & ~ps2_clk_oe;
    assign datLine = bfmDat & ~ps2_dat_oe;

    ps2_host_tx #(
        .CLK_FREQ_HZ      (CLK_HZ),
        .INHIBIT_US       (INH_US),
        .START_TIMEOUT_US (START_US),
        .XFER_TIMEOUT_US  (XFER_US),
        .FILTER_LEN       (8)
    ) dut (
        .CLOCK_50   (CLOCK_50),
        .RESET      (RESET),
        .tx_data    (tx_data),
        .tx_valid   (tx_valid),
        .tx_ready   (tx_ready),
        .tx_done    (tx_done),
        .tx_error   (tx_error),
        .busy       (busy),
        .ps2_clk_in (clkLine),
        .ps2_dat_in (datLine),
        .ps2_clk_oe (ps2_clk_oe),
        .ps2_dat_oe (ps2_dat_oe)
    );

    always #5 CLOCK_50 = ~CLOCK_50;

    always @(posedge CLOCK_50) cycle <= cycle + 1;

    // Pulse counters and the length of the most recent clock-inhibit run.
    always @(negedge CLOCK_50) begin
        if (tx_done) doneCount <= doneCount + 1;
        if (tx_error) begin
            errCount <= errCount + 1;
            errCycle <= cycle;
        end
        if (ps2_clk_oe) begin
            lowRun <= lowRun + 1;
        end else if (lowRun != 0) begin
            lastLowRun <= lowRun;
            lowRun     <= 0;
        end
    end

    initial begin
        #800000;
        $display("[TB] FAIL watchdog: simulation did not finish, observed running, expected finished");
        $fatal(1, "[TB] watchdog expired");
    end

    task automatic tick();
        @(negedge CLOCK_50);
        #1;
    endtask

    task automatic checkOutput(input string tag, input logic [31:0] observed,
                               input logic [31:0] expected);
        assertCount++;
        assert (observed === expected) else begin
            failCount++;
            $error("[TB] FAIL %s: observed %0h, expected %0h (byte %02h)",
                   tag, observed, expected, curData);
        end
    endtask

    task automatic checkRange(input string tag, input int observed,
                              input int lo, input int hi);
        assertCount++;
        assert (observed >= lo && observed <= hi) else begin
            failCount++;
            $error("[TB] FAIL %s: observed %0d, expected %0d..%0d (byte %02h)",
                   tag, observed, lo, hi, curData);
        end
    endtask

    function automatic logic [10:0] expFrame(input logic [7:0] data);
        int   ones;
        logic par;
        ones = $countones(data);
        par  = ((ones % 2) == 0);
        return {1'b1, par, data, 1'b0};
    endfunction

    task automatic applyStimulus(input logic [7:0] data);
        curData    = data;
        lastLowRun = 0;
        tx_data    = data;
        tx_valid   = 1'b1;
        tick();
        tx_valid   = 1'b0;
        checkOutput("accept_busy", busy, 1);
    endtask

    // Waits for the clock release with the start bit present.
    task automatic waitRequest(output bit ok, output int relCycle);
        ok       = 1'b0;
        relCycle = 0;
        for (int i = 0; i < INH_CYC + 100; i++) begin
            tick();
            if (clkLine && !datLine) begin
                ok       = 1'b1;
                relCycle = cycle;
                break;
            end
        end
    endtask

    task automatic devicePeriod(input bit ackDrive, input bit glitch,
                                output bit sampled, output int fallAt);
        sampled = 1'b1;
        bfmClk  = 1'b1;
        for (int i = 0; i < HALF; i++) begin
            tick();
            if (glitch && i == 20) bfmClk = 1'b0;
            if (glitch && i == 23) bfmClk = 1'b1;
            if (i == HALF / 2) sampled = datLine;
            if (ackDrive && i == HALF / 2 + 10) bfmDat = 1'b0;
        end
        bfmClk = 1'b0;
        fallAt = cycle;
        for (int i = 0; i < HALF; i++) tick();
    endtask

    task automatic deviceFrame(input int nFalls, input bit ackDrive, input int glitchP,
                               output logic [10:0] frame, output int firstFall);
        bit b;
        int f;
        frame     = '0;
        firstFall = 0;
        for (int p = 0; p < nFalls; p++) begin
            devicePeriod(ackDrive && (p == 10), p == glitchP, b, f);
            if (p == 0) firstFall = f;
            frame[p] = b;
        end
        bfmClk = 1'b1;
        bfmDat = 1'b1;
    endtask

    task automatic waitPulse(input int budget, output bit ok);
        int base;
        base = doneCount + errCount;
        ok   = 1'b0;
        for (int i = 0; i < budget; i++) begin
            tick();
            if (doneCount + errCount != base) begin
                ok = 1'b1;
                break;
            end
        end
    endtask

    task automatic runFrame(input logic [7:0] data, input int glitchP,
                            input bit ackOk, input bit pokeBusy);
        bit          ok;
        int          relCycle, fallAt, d0, e0;
        logic [10:0] frame;
        applyStimulus(data);
        if (pokeBusy) begin
            tx_data  = ~data;
            tx_valid = 1'b1;
        end
        waitRequest(ok, relCycle);
        tx_valid = 1'b0;
        tx_data  = data;
        checkOutput("request_seen", ok, 1);
        checkRange("inhibit_low_cycles", lastLowRun, INH_CYC, INH_CYC + 1);
        d0 = doneCount;
        e0 = errCount;
        deviceFrame(11, ackOk, glitchP, frame, fallAt);
        checkOutput("frame_bits", 32'(frame), 32'(expFrame(data)));
        waitPulse(4 * HALF, ok);
        checkOutput("pulse_seen", ok, 1);
        checkOutput("done_pulses", doneCount - d0, 32'(ackOk));
        checkOutput("error_pulses", errCount - e0, 32'(!ackOk));
        checkOutput("ready_in_pulse_cycle", tx_ready, 0);
        tick();
        checkOutput("ready_after_pulse", tx_ready, 1);
        checkOutput("lines_released", {ps2_clk_oe, ps2_dat_oe}, 0);
    endtask

    initial begin
        bit          ok;
        int          relCycle, fallAt, d0, e0;
        logic [10:0] frame, expect11;
        logic [7:0]  data;

        $display("[TB] ps2_host_tx bench starting");

        repeat (3) tick();
        checkOutput("reset_ready", tx_ready, 1);
        checkOutput("reset_busy", busy, 0);
        checkOutput("reset_oe", {ps2_clk_oe, ps2_dat_oe}, 0);
        checkOutput("reset_pulses", {tx_done, tx_error}, 0);
        RESET = 1'b0;
        tick();

        // Directed bytes, with a competing request held during the first.
        runFrame(PS2_CMD_SETLED, -1, 1'b1, 1'b1);
        runFrame(8'h00, -1, 1'b1, 1'b0);
        runFrame(8'h01, -1, 1'b1, 1'b0);
        runFrame(8'hFF, -1, 1'b1, 1'b0);

        for (int n = 0; n < 3; n++) begin
            runFrame(8'($urandom), -1, 1'b1, 1'b0);
        end

        // Short clock glitch in the middle of the data bits.
        runFrame(8'($urandom), 4, 1'b1, 1'b0);

        // Keyboard leaves data high at the ACK edge.
        runFrame(8'($urandom), -1, 1'b0, 1'b0);

        // Keyboard never clocks.
        applyStimulus(PS2_CMD_RESET);
        waitRequest(ok, relCycle);
        checkOutput("start_request_seen", ok, 1);
        d0 = doneCount;
        e0 = errCount;
        waitPulse(START_CYC + 100, ok);
        checkOutput("start_timeout_seen", ok, 1);
        checkOutput("start_timeout_delay", errCycle - relCycle, START_CYC);
        checkOutput("start_timeout_errors", errCount - e0, 1);
        checkOutput("start_timeout_done", doneCount - d0, 0);
        checkOutput("start_timeout_lines", {ps2_clk_oe, ps2_dat_oe}, 0);
        checkOutput("start_timeout_ready_pulse", tx_ready, 0);
        tick();
        checkOutput("start_timeout_ready_after", tx_ready, 1);

        // Keyboard stops after four clocks.
        applyStimulus(8'($urandom));
        waitRequest(ok, relCycle);
        checkOutput("stall_request_seen", ok, 1);
        d0 = doneCount;
        e0 = errCount;
        deviceFrame(4, 1'b0, -1, frame, fallAt);
        waitPulse(XFER_CYC + 200, ok);
        checkOutput("stall_error_seen", ok, 1);
        checkRange("stall_error_delay", errCycle - fallAt, XFER_CYC, XFER_CYC + 30);
        checkOutput("stall_errors", errCount - e0, 1);
        checkOutput("stall_done", doneCount - d0, 0);
        checkOutput("stall_lines", {ps2_clk_oe, ps2_dat_oe}, 0);
        tick();
        checkOutput("stall_ready_after", tx_ready, 1);

        // Reset while bit 3 (forced to 0) is being driven.
        data = 8'($urandom) & 8'hF7;
        applyStimulus(data);
        waitRequest(ok, relCycle);
        checkOutput("reset_mid_request_seen", ok, 1);
        d0 = doneCount;
        e0 = errCount;
        deviceFrame(4, 1'b0, -1, frame, fallAt);
        expect11 = expFrame(data);
        checkOutput("reset_mid_first_bits", 32'(frame[3:0]), 32'(expect11[3:0]));
        tick();
        checkOutput("reset_mid_bit3_low", ps2_dat_oe, 1);
        RESET = 1'b1;
        #1;
        checkOutput("reset_mid_clk_oe_async", ps2_clk_oe, 0);
        checkOutput("reset_mid_dat_oe_async", ps2_dat_oe, 0);
        repeat (3) tick();
        RESET = 1'b0;
        tick();
        checkOutput("reset_mid_no_pulse", (doneCount - d0) + (errCount - e0), 0);
        checkOutput("reset_mid_ready", tx_ready, 1);
        runFrame(PS2_CMD_ENABLE, -1, 1'b1, 1'b0);

        $display("End of test - %0d assertions evaluated, %0d failures", assertCount, failCount);
        $finish;
    end

endmodule
